// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: host/memory-side signal bundle of the FFT address sequencer.
//   master modport : the sequencer (takes Start/Ack/Hold, drives addressing outputs)
//   slave  modport : the host / memory controller
//   Start, Ack, Hold   : host requests, completion acknowledge, memory busy
//   issue, i_top/i_bot : butterfly operand read strobe and pair addresses
//   tw_idx             : twiddle exponent for W_N
//   wr_en, wr_top/bot  : result write strobe and addresses (issue delayed LAT cycles)
//   stage, Done, state : progress / status
interface fft_sequencer_if #(
    parameter int unsigned LOG2N = 10
);
    logic             Start;
    logic             Ack;
    logic             Hold;
    logic             issue;
    logic [LOG2N-1:0] i_top;
    logic [LOG2N-1:0] i_bot;
    logic [LOG2N-2:0] tw_idx;
    logic             wr_en;
    logic [LOG2N-1:0] wr_top;
    logic [LOG2N-1:0] wr_bot;
    logic [3:0]       stage;
    logic             Done;
    logic [3:0]       state;

    modport master (
        input  Start, Ack, Hold,
        output issue, i_top, i_bot, tw_idx, wr_en, wr_top, wr_bot, stage, Done, state
    );

    modport slave (
        output Start, Ack, Hold,
        input  issue, i_top, i_bot, tw_idx, wr_en, wr_top, wr_bot, stage, Done, state
    );
endinterface

// File: rtl/fft_sequencer.sv
// fft_sequencer: radix-2 in-place decimation-in-time FFT address generator.
// Produces butterfly read addresses, twiddle index and delayed write-back
// addresses for an N = 2^LOG2N point transform whose input sits in memory in
// bit-reversed order. No data path.
//   Clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : fft_sequencer_if.master (see interface file for signal list)
module fft_sequencer #(
    parameter int unsigned LOG2N = 10,
    parameter int unsigned LAT   = 3
) (
    input  logic               Clk,
    input  logic               Reset_n,
    fft_sequencer_if.master    bus
);

    localparam int unsigned      HalfN   = 2 ** (LOG2N - 1);
    localparam logic [LOG2N-2:0] KLast   = (LOG2N - 1)'(HalfN - 1);
    localparam logic [3:0]       SLast   = 4'(LOG2N - 1);
    localparam int unsigned      CntW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CntW-1:0]  CntLast = CntW'((LAT == 0) ? 0 : LAT - 1);

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StDone  = 4'd1,
        StProc  = 4'd2,
        StDrain = 4'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [LOG2N-1:0] top_q, top_d, bot_q, bot_d;
    logic [LOG2N-2:0] tw_q, tw_d;
    logic             issue;

    logic [LOG2N-1:0] kx, mask, p;

    // Next-state and issue decode.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d = StProc;
                    s_d     = 4'd0;
                    k_d     = '0;
                end
            end
            StProc: begin
                if (!bus.Hold) begin
                    issue = 1'b1;
                    if (k_q == KLast) begin
                        k_d = '0;
                        if (LAT == 0) begin
                            // No pipe to drain: step straight to the next stage.
                            if (s_q == SLast) state_d = StDone;
                            else              s_d     = s_q + 4'd1;
                        end else begin
                            state_d = StDrain;
                            cnt_d   = '0;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Wait until the last write of this stage has left the pipe.
                if (cnt_q == CntLast) begin
                    if (s_q == SLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StProc;
                        s_d     = s_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.Ack) begin
                    state_d = StIdle;
                    s_d     = 4'd0;
                    k_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Address of butterfly k_d in stage s_d, registered so outputs line up with
    // the counter: span = 2^s, p = k mod span, j = k >> s.
    always_comb begin
        kx    = {1'b0, k_d};
        mask  = (LOG2N'(1) << s_d) - LOG2N'(1);
        p     = kx & mask;
        top_d = '0;
        bot_d = '0;
        tw_d  = '0;
        if (state_d == StProc) begin
            top_d = ((kx >> s_d) << (s_d + 4'd1)) | p;
            // Bit s of top is always clear, so OR is the same as adding span.
            bot_d = top_d | (LOG2N'(1) << s_d);
            tw_d  = (LOG2N - 1)'(p << (SLast - s_d));
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            s_q     <= 4'd0;
            k_q     <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            tw_q    <= tw_d;
        end
    end

    // Write-back pipe: free-running, never stalled by Hold.
    if (LAT == 0) begin : g_direct
        assign bus.wr_en  = issue;
        assign bus.wr_top = top_q;
        assign bus.wr_bot = bot_q;
    end else begin : g_pipe
        logic [LAT-1:0]   vld_q;
        logic [LOG2N-1:0] top_pipe_q [LAT];
        logic [LOG2N-1:0] bot_pipe_q [LAT];

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                vld_q <= '0;
                for (int i = 0; i < LAT; i++) begin
                    top_pipe_q[i] <= '0;
                    bot_pipe_q[i] <= '0;
                end
            end else begin
                vld_q[0]      <= issue;
                top_pipe_q[0] <= top_q;
                bot_pipe_q[0] <= bot_q;
                for (int i = LAT - 1; i > 0; i--) begin
                    vld_q[i]      <= vld_q[i-1];
                    top_pipe_q[i] <= top_pipe_q[i-1];
                    bot_pipe_q[i] <= bot_pipe_q[i-1];
                end
            end
        end

        assign bus.wr_en  = vld_q[LAT-1];
        assign bus.wr_top = top_pipe_q[LAT-1];
        assign bus.wr_bot = bot_pipe_q[LAT-1];
    end

    assign bus.issue  = issue;
    assign bus.i_top  = top_q;
    assign bus.i_bot  = bot_q;
    assign bus.tw_idx = tw_q;
    assign bus.stage  = s_q;
    assign bus.Done   = (state_q == StDone);
    assign bus.state  = state_q;

endmodule

// File: tb/tb_fft_sequencer.sv
module tb_fft_sequencer;

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    fft_sequencer_if #(.LOG2N(3))  bus ();
    fft_sequencer_if #(.LOG2N(10)) bus2 ();

    fft_sequencer #(.LOG2N(3), .LAT(2)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    fft_sequencer #(.LOG2N(10), .LAT(0)) dut2 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus2)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Hand-derived DIT pair/twiddle table for N=8.
    int exp_top [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_bot [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ack_done();
        bus.Ack = 1'b1;
        @(posedge Clk);
        #1 bus.Ack = 1'b0;
    endtask

    // Full transform on the N=8 instance; Hold for hold_len cycles before stage1 k=2.
    task automatic run_main(input int hold_len, input string tag);
        int         t         = 0;
        int         idx       = 0;
        int         proc      = 0;
        int         drain     = 0;
        int         wr_cnt    = 0;
        int         hold_left = hold_len;
        bit         done      = 1'b0;
        logic [6:0] hist [$];
        logic [6:0] expw;
        bus.Start = 1'b1;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        while (!done && t < 60) begin
            if (bus.state == 4'd1) begin
                done = 1'b1;
            end else begin
                bus.Hold = (idx == 6 && hold_left > 0);
                #1;
                if (bus.Hold) begin
                    check({tag, " hold issue"}, bus.issue, 0);
                    check({tag, " hold i_top"}, bus.i_top, 4);
                    check({tag, " hold i_bot"}, bus.i_bot, 6);
                    hold_left--;
                end
                if (bus.state == 4'd2 || bus.state == 4'd3) proc++;
                if (bus.state == 4'd3) drain++;
                hist.push_back({bus.issue, bus.i_top, bus.i_bot});
                expw = (t >= 2) ? hist[t-2] : 7'd0;
                check({tag, " wr_en"}, bus.wr_en, expw[6]);
                if (expw[6]) check({tag, " wr addr"}, {bus.wr_top, bus.wr_bot}, expw[5:0]);
                if (bus.wr_en) wr_cnt++;
                if (bus.issue) begin
                    if (idx < 12) begin
                        check({tag, " i_top"}, bus.i_top, exp_top[idx]);
                        check({tag, " i_bot"}, bus.i_bot, exp_bot[idx]);
                        check({tag, " tw_idx"}, bus.tw_idx, exp_tw[idx]);
                        check({tag, " stage"}, bus.stage, idx / 4);
                    end
                    idx++;
                end
                t++;
                @(posedge Clk);
                #1;
            end
        end
        bus.Hold = 1'b0;
        check({tag, " reached DONE"}, done, 1);
        check({tag, " proc+drain cycles"}, proc, 18 + hold_len);
        check({tag, " drain cycles"}, drain, 6);
        check({tag, " issue count"}, idx, 12);
        check({tag, " wr_en count"}, wr_cnt, 12);
        check({tag, " Done"}, bus.Done, 1);
        check({tag, " state"}, bus.state, 1);
        check({tag, " wr_en idle"}, bus.wr_en, 0);
    endtask

    initial begin
        int  cnt;
        int  proc;
        int  bad;
        int  last_top;
        int  last_bot;
        int  last_tw;
        bit  hit;

        Reset_n    = 1'b0;
        bus.Start  = 1'b0;
        bus.Ack    = 1'b0;
        bus.Hold   = 1'b0;
        bus2.Start = 1'b0;
        bus2.Ack   = 1'b0;
        bus2.Hold  = 1'b0;
        #3;
        check("reset state", bus.state, 0);
        check("reset issue", bus.issue, 0);
        check("reset wr_en", bus.wr_en, 0);
        check("reset addrs", {bus.i_top, bus.i_bot, bus.tw_idx}, 0);
        check("reset Done", bus.Done, 0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("idle no start", bus.state, 0);

        run_main(0, "base");

        // DONE persists without Ack.
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            check("done hold state", bus.state, 1);
            check("done hold Done", bus.Done, 1);
        end
        // Ack with simultaneous Start returns to IDLE and does not restart.
        bus.Ack   = 1'b1;
        bus.Start = 1'b1;
        @(posedge Clk);
        #1 bus.Ack = 1'b0;
        bus.Start = 1'b0;
        check("ack state", bus.state, 0);
        check("ack Done", bus.Done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check("post ack idle", bus.state, 0);
            check("post ack issue", bus.issue, 0);
        end

        run_main(3, "hold");
        ack_done();

        // Abort mid-transform at stage1 k=1.
        bus.Start = 1'b1;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (bus.issue && bus.stage == 4'd1 && bus.i_top == 3'd1) hit = 1'b1;
            else begin
                @(posedge Clk);
                #1;
            end
        end
        check("abort point reached", hit, 1);
        #1 Reset_n = 1'b0;
        #1;
        check("abort state", bus.state, 0);
        check("abort issue", bus.issue, 0);
        check("abort wr_en", bus.wr_en, 0);
        check("abort addrs", {bus.i_top, bus.i_bot, bus.tw_idx, bus.stage}, 0);
        check("abort Done", bus.Done, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            check("in reset wr_en", bus.wr_en, 0);
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check("after abort wr_en", bus.wr_en, 0);
            check("after abort state", bus.state, 0);
        end

        run_main(0, "rerun");
        ack_done();

        // N=1024, LAT=0 instance.
        cnt      = 0;
        proc     = 0;
        bad      = 0;
        last_top = -1;
        last_bot = -1;
        last_tw  = -1;
        bus2.Start = 1'b1;
        @(posedge Clk);
        #1 bus2.Start = 1'b0;
        for (int i = 0; i < 6000 && bus2.state != 4'd1; i++) begin
            if (bus2.state == 4'd2 || bus2.state == 4'd3) proc++;
            if (bus2.wr_en !== bus2.issue) bad++;
            if (bus2.issue) begin
                cnt++;
                if (bus2.wr_top !== bus2.i_top || bus2.wr_bot !== bus2.i_bot) bad++;
                last_top = int'(bus2.i_top);
                last_bot = int'(bus2.i_bot);
                last_tw  = int'(bus2.tw_idx);
            end
            @(posedge Clk);
            #1;
        end
        check("big issue count", cnt, 5120);
        check("big proc cycles", proc, 5120);
        check("big wr coincident", bad, 0);
        check("big last i_top", last_top, 511);
        check("big last i_bot", last_bot, 1023);
        check("big last tw_idx", last_tw, 511);
        check("big state", bus2.state, 1);
        check("big Done", bus2.Done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter LOG2N, default 10, log2 of transform length N (N = 2^LOG2N points, radix-2, in-place).
REQ-002 Parameter LAT, default 3, butterfly latency in cycles from issue to result valid (0 allowed).
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  in  1  reset is asynchronous and active-low.
REQ-005 Start  in  1  request a transform; sampled only in IDLE.
REQ-006 Ack  in  1  host acknowledges completion; sampled only in DONE.
REQ-007 Hold  in  1  memory busy; suppresses issue while high.
REQ-008 issue  out  1  butterfly operands valid this cycle.
REQ-009 i_top, i_bot  out  LOG2N  read addresses of the butterfly pair.
REQ-010 tw_idx  out  LOG2N-1  twiddle index, W_N^tw_idx.
REQ-011 wr_en  out  1  write results back this cycle.
REQ-012 wr_top, wr_bot  out  LOG2N  write addresses (issue addresses delayed LAT cycles).
REQ-013 stage  out  4  current stage number s, 0..LOG2N-1.
REQ-014 Done  out  1  high while in DONE.
REQ-015 state  out  4  IDLE=0, DONE=1, PROC=2, DRAIN=3.

Function
REQ-016 Input data is in bit-reversed order in memory; block generates decimation-in-time addressing only, no data path.
REQ-017 Butterfly counter k runs 0..N/2-1 per stage; span=2^s, p=k mod span, j=k>>s.
REQ-018 i_top = (j<<(s+1)) | p; i_bot = i_top + span; tw_idx = p<<(LOG2N-1-s); all registered outputs.
REQ-019 IDLE: Start=1 -> PROC next cycle with s=0, k=0; Start otherwise ignored in every state but IDLE.
REQ-020 PROC: issue=1 and k increments each cycle Hold=0; Hold=1 -> issue=0, k, s, addresses frozen.
REQ-021 Issue of k=N/2-1 with Hold=0 -> DRAIN next cycle (LAT=0: skip DRAIN, go directly to next stage or DONE).
REQ-022 DRAIN lasts exactly LAT cycles, issue=0; then s+1 and k=0 in PROC, or DONE if s=LOG2N-1.
REQ-023 No operand of stage s+1 issued before last wr_en of stage s (read-after-write hazard guaranteed by DRAIN).
REQ-024 Write pipe: wr_en/wr_top/wr_bot equal issue/i_top/i_bot delayed exactly LAT cycles; Hold does not stall the pipe.
REQ-025 DONE: Done=1, held until Ack=1 -> IDLE next cycle; Start in same cycle as Ack ignored.
REQ-026 Total PROC+DRAIN cycles with Hold=0: LOG2N*(N/2+LAT); each Hold cycle adds one.
REQ-027 Exactly LOG2N*N/2 issue pulses and the same number of wr_en pulses per transform.

Reset
REQ-028 Reset_n=0 asynchronously forces state=IDLE, s=0, k=0, issue=0, wr_en=0, Done=0, all addresses and tw_idx 0, write pipe cleared.
REQ-029 Reset mid-transform aborts immediately; no wr_en after reset asserts; Start required to restart.

Verification (LOG2N=3, LAT=2 unless stated)
REQ-030 Start pulse from IDLE -> issue pairs stage0 (0,1)(2,3)(4,5)(6,7) tw 0,0,0,0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
REQ-031 Same run -> 18 cycles in PROC/DRAIN, 2 DRAIN cycles after each stage, each wr_en 2 cycles after its issue with matching addresses, then Done=1, state=1.
REQ-032 Hold=1 for 3 cycles at stage1 k=2 -> issue low, addresses held at (4,6), 21 cycles total, write pipe drains undisturbed.
REQ-033 Done held 5 cycles with Ack=0 -> stays DONE; Ack=1 together with Start=1 -> IDLE, no new transform.
REQ-034 Reset_n low at stage1 k=1 -> outputs 0 and state=0 immediately, no further wr_en; later Start runs full sequence from stage0.
REQ-035 LOG2N=10, LAT=0 -> 5120 issue cycles, wr_en coincident with issue, last pair (511,1023) tw 511, then DONE.
